control_sumaresta: RTL and testbench

- Control and state stage wrapped around the combinational add/subtract stage: sumaresta takes A[1:0] and Q[3:0] and returns D[3:0].
- Synchronises and debounces two push-buttons (up/down).
- Issues a one-cycle operation code on A, then loads the returned D into the 4-bit state register that drives Q.
- Forms the closed loop of the board's up/down counter.

---
 rtl/control_sumaresta.sv | 104 ++++++++++
 tb/tb_control_sumaresta.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sumaresta.sv
// Up/down counter control: button synchronisers, debouncers, rise detection and a small
// FSM that issues one op code per press and loads the arithmetic stage's result into Q.
module control_sumaresta #(
   parameter int unsigned DEBOUNCE_CYCLES = 12000,
   parameter int unsigned CNT_W           = 14
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [3:0] D,
   output logic [1:0] A,
   output logic [3:0] Q,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StCmd, StWaitRel} state_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       btn_raw, sync1_q, sync2_q, deb_q, deb_prev_q, rise;
   logic [CNT_W-1:0] cnt_q [2];
   logic [1:0]       a_q, a_d;
   logic             busy_q, busy_d;
   logic [3:0]       q_q;

   // Bit 0 carries the up button, bit 1 the down button throughout.
   assign btn_raw = {btn_down, btn_up};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         deb_prev_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntMax) begin
               deb_q[i] <= ~deb_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise = deb_q & ~deb_prev_q;

   always_comb begin
      state_d = state_q;
      a_d     = 2'b00;
      case (state_q)
         StIdle: begin
            // A rise only counts if the other button is idle; anything else waits for release.
            if (rise == 2'b01 && !deb_q[1]) begin
               state_d = StCmd;
               a_d     = 2'b01;
            end else if (rise == 2'b10 && !deb_q[0]) begin
               state_d = StCmd;
               a_d     = 2'b10;
            end else if (rise != 2'b00) begin
               state_d = StWaitRel;
            end
         end
         StCmd:     state_d = StWaitRel;
         StWaitRel: if (deb_q == 2'b00) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
         a_q     <= 2'b00;
         busy_q  <= 1'b0;
         q_q     <= 4'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         busy_q  <= busy_d;
         if (state_q == StCmd) q_q <= D;
      end
   end

   assign A    = a_q;
   assign Q    = q_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_control_sumaresta.sv
// Bench for control_sumaresta with a behavioural add/subtract stage closing the loop;
// expected op/result pairs are queued on stimulus and checked as A pulses appear.
module tb_control_sumaresta;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [3:0] D;
   logic [1:0] A;
   logic [3:0] Q;
   logic       busy;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      bit up;
      bit down;
      int hold;
      bit step;
      bit busy_exp;
   } vec_t;

   typedef struct {
      logic [1:0] a;
      logic [3:0] q;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] model_q = 4'd0;
   vec_t       vecs [9];
   bit         pend = 1'b0;
   logic [3:0] pend_q = 4'd0;

   control_sumaresta #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .btn_up  (btn_up),
      .btn_down(btn_down),
      .D       (D),
      .A       (A),
      .Q       (Q),
      .busy    (busy)
   );

   // Stand-in for the arithmetic stage, modulo 16.
   always_comb begin
      D = Q;
      if (A == 2'b01) D = Q + 4'd1;
      else if (A == 2'b10) D = Q - 4'd1;
   end

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_step(input logic [1:0] op);
      if (op == 2'b01) model_q = model_q + 4'd1;
      else model_q = model_q - 4'd1;
      sb.push_back('{a: op, q: model_q});
   endtask

   task automatic press(input bit up, input bit down, input int hold, input bit step,
                        input bit busy_exp, input string name);
      if (step) push_step(up ? 2'b01 : 2'b10);
      @(negedge clk);
      btn_up   = up;
      btn_down = down;
      repeat (hold) @(negedge clk);
      check({name, "_busy_hold"}, 32'(busy), 32'(busy_exp));
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (15) @(negedge clk);
      check({name, "_q"}, 32'(Q), 32'(model_q));
      check({name, "_busy_rel"}, 32'(busy), 32'd0);
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every A pulse must match a queued expectation and last one cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pend) begin
            pend = 1'b0;
            check("q_after_cmd", 32'(Q), 32'(pend_q));
            check("a_one_cycle", 32'(A), 32'd0);
         end else if (rstn && A != 2'b00) begin
            if (sb.size() == 0) begin
               check("unexpected_a", 32'(A), 32'd0);
            end else begin
               e = sb.pop_front();
               check("a_op", 32'(A), 32'(e.a));
               pend   = 1'b1;
               pend_q = e.q;
            end
         end
      end
   end

   initial begin
      int  bw [10] = '{1, 2, 3, 1, 2, 3, 2, 1, 3, 2};
      bit  seen;

      vecs[0] = '{1'b1, 1'b0, 10, 1'b1, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 10, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 10, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 10, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 10, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 3,  1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 3,  1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 4,  1'b1, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 4,  1'b1, 1'b0};

      // Reset with both buttons held; they must not step until released.
      btn_up   = 1'b1;
      btn_down = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_q", 32'(Q), 32'd0);
      check("rst_a", 32'(A), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      repeat (15) @(negedge clk);
      check("held_busy", 32'(busy), 32'd1);
      check("held_q", 32'(Q), 32'd0);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (15) @(negedge clk);
      check("held_rel_busy", 32'(busy), 32'd0);
      check("held_rel_q", 32'(Q), 32'd0);

      for (int i = 0; i < 9; i++)
         press(vecs[i].up, vecs[i].down, vecs[i].hold, vecs[i].step, vecs[i].busy_exp,
               $sformatf("vec%0d", i));

      // Bouncing up button, no run of 4 high cycles.
      for (int i = 0; i < 10; i++) begin
         btn_up = (i % 2 == 0);
         repeat (bw[i]) @(negedge clk);
      end
      btn_up = 1'b0;
      repeat (12) @(negedge clk);
      check("bounce_q", 32'(Q), 32'(model_q));
      check("bounce_busy", 32'(busy), 32'd0);
      press(1'b1, 1'b0, 10, 1'b1, 1'b1, "bounce_settle");

      // Down pressed while up is held: only the up step.
      push_step(2'b01);
      btn_up = 1'b1;
      repeat (10) @(negedge clk);
      btn_down = 1'b1;
      repeat (10) @(negedge clk);
      check("ovl_busy_both", 32'(busy), 32'd1);
      btn_up = 1'b0;
      repeat (10) @(negedge clk);
      check("ovl_busy_down", 32'(busy), 32'd1);
      btn_down = 1'b0;
      repeat (15) @(negedge clk);
      check("ovl_q", 32'(Q), 32'(model_q));
      check("ovl_busy_rel", 32'(busy), 32'd0);
      check("ovl_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during the command cycle: Q must clear instead of taking D.
      sb.push_back('{a: 2'b01, q: 4'd0});
      btn_up = 1'b1;
      seen   = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (A == 2'b01) seen = 1'b1;
      end
      check("midcmd_a_seen", 32'(seen), 32'd1);
      rstn   = 1'b0;
      btn_up = 1'b0;
      @(negedge clk);
      #1;
      check("midcmd_q", 32'(Q), 32'd0);
      check("midcmd_a", 32'(A), 32'd0);
      check("midcmd_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rstn    = 1'b1;
      model_q = 4'd0;
      repeat (10) @(negedge clk);
      check("midcmd_sb_empty", 32'(sb.size()), 32'd0);
      press(1'b1, 1'b0, 10, 1'b1, 1'b1, "post_rst_up");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
